div_seq: RTL and testbench

Multi-cycle, parametrised integer divider for the MIPS datapath, servicing DIV and DIVU. Computes quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor with a restoring radix-2 algorithm, one quotient bit per cycle. Sits beside the ALU; the control unit stalls on `busy` and writes `quotient` to LO and `remainder` to HI on `done`.

---
 rtl/div_pkg.sv | 8 +
 rtl/div_step.sv | 22 ++
 rtl/div_seq.sv | 109 ++++++++++
 tb/tb_div_seq.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared FSM state encoding and two's-complement helper for the sequential divider.
package div_pkg;
    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_e;
    localparam int MAX_W = 64;
    function automatic logic [MAX_W-1:0] twos_neg(input logic [MAX_W-1:0] x);
        return ~x + MAX_W'(1);
    endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one restoring radix-2 iteration, shift in the next dividend bit and trial-subtract |divisor|.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    always_comb begin
        shifted = {rem_i, bit_i};
        trial   = shifted - {1'b0, div_i};
        // the partial remainder stays below |divisor|, so a set top bit always means trial >= 0
        q_o     = shifted[WIDTH] | ~trial[WIDTH];
        rem_o   = q_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end
endmodule

// File: rtl/div_seq.sv
// div_seq: multi-cycle restoring divider for DIV/DIVU, one quotient bit per cycle, WIDTH+2 cycle latency.
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH) + 1;
    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, r_q, r_d, b_q, b_d, raw_q, raw_d, quo_q, quo_d, rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             nq_q, nq_d, nr_q, nr_d, dbz_q, dbz_d;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i(r_q),
        .bit_i(a_q[WIDTH-1]),
        .div_i(b_q),
        .rem_o(step_rem),
        .q_o  (step_q)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        r_d     = r_q;
        b_d     = b_q;
        raw_d   = raw_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        nq_d    = nq_q;
        nr_d    = nr_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = start ? CALC : IDLE;
                if (start) begin
                    a_d   = (is_signed && dividend[WIDTH-1]) ? WIDTH'(twos_neg(MAX_W'(dividend))) : dividend;
                    b_d   = (is_signed && divisor[WIDTH-1]) ? WIDTH'(twos_neg(MAX_W'(divisor))) : divisor;
                    raw_d = dividend;
                    nq_d  = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    nr_d  = is_signed & dividend[WIDTH-1];
                    r_d   = '0;
                    cnt_d = '0;
                end
            end
            CALC: begin
                a_d     = {a_q[WIDTH-2:0], step_q};
                r_d     = step_rem;
                cnt_d   = cnt_q + CW'(1);
                state_d = (cnt_q == CW'(WIDTH - 1)) ? SIGN : CALC;
            end
            SIGN: begin
                dbz_d   = (b_q == '0);
                quo_d   = dbz_d ? '1 : nq_q ? WIDTH'(twos_neg(MAX_W'(a_q))) : a_q;
                rem_d   = dbz_d ? raw_q : nr_q ? WIDTH'(twos_neg(MAX_W'(r_q))) : r_q;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            r_q     <= '0;
            b_q     <= '0;
            raw_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            nq_q    <= 1'b0;
            nr_q    <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            r_q     <= r_d;
            b_q     <= b_d;
            raw_q   <= raw_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            nq_q    <= nq_d;
            nr_q    <= nr_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == CALC) || (state_q == SIGN);
    assign done        = (state_q == DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: scoreboard bench for div_seq at WIDTH=32 and WIDTH=8 against a reference built on native division.
module tb_div_seq;
    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        bit          z;
        int          c0;
    } exp_t;

    logic        clk = 1'b0, reset = 1'b1;
    logic        start32 = 1'b0, sgn32 = 1'b0, start8 = 1'b0, sgn8 = 1'b0;
    logic [31:0] dvd32 = '0, dvs32 = '0, q32, r32;
    logic [7:0]  dvd8 = '0, dvs8 = '0, q8, r8;
    logic        busy32, done32, dbz32, busy8, done8, dbz8;
    int          cyc = 0, n_chk = 0, n_err = 0, n_done = 0;
    exp_t        sb32[$];
    exp_t        sb8[$];

    div_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .is_signed(sgn32),
        .dividend(dvd32), .divisor(dvs32), .busy(busy32), .done(done32),
        .quotient(q32), .remainder(r32), .div_by_zero(dbz32)
    );

    div_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .is_signed(sgn8),
        .dividend(dvd8), .divisor(dvs8), .busy(busy8), .done(done8),
        .quotient(q8), .remainder(r8), .div_by_zero(dbz8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model(input int w, input bit s, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] q, output logic [63:0] r, output bit z);
        logic [63:0] m;
        longint      sa, sb;
        m = (64'd1 << w) - 64'd1;
        z = (b == 0);
        if (z) begin
            q = m;
            r = a;
        end else if (s) begin
            sa = $signed(a << (64 - w)) >>> (64 - w);
            sb = $signed(b << (64 - w)) >>> (64 - w);
            q  = 64'(sa / sb) & m;
            r  = 64'(sa % sb) & m;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // called on a negedge; start is accepted on the following posedge
    task automatic go32(input bit s, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        start32 = 1'b1;
        sgn32   = s;
        dvd32   = a;
        dvs32   = b;
        model(32, s, 64'(a), 64'(b), e.q, e.r, e.z);
        @(negedge clk);
        e.c0    = cyc;
        sb32.push_back(e);
        start32 = 1'b0;
    endtask

    task automatic go8(input bit s, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        start8 = 1'b1;
        sgn8   = s;
        dvd8   = a;
        dvs8   = b;
        model(8, s, 64'(a), 64'(b), e.q, e.r, e.z);
        @(negedge clk);
        e.c0   = cyc;
        sb8.push_back(e);
        start8 = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (sb32.size() + sb8.size()) != 0; i++) @(negedge clk);
        chk("drain_timeout", 64'(sb32.size() + sb8.size()), 64'd0);
        @(negedge clk);
    endtask

    always @(negedge clk) begin : mon32
        exp_t e;
        if (!reset && done32) begin
            n_done++;
            if (sb32.size() == 0) chk("spurious_done32", 64'd1, 64'd0);
            else begin
                e = sb32.pop_front();
                chk("q32", 64'(q32), e.q);
                chk("r32", 64'(r32), e.r);
                chk("dbz32", 64'(dbz32), 64'(e.z));
                chk("lat32", 64'(cyc - e.c0 + 1), 64'd34);
            end
        end
    end

    always @(negedge clk) begin : mon8
        exp_t e;
        if (!reset && done8) begin
            if (sb8.size() == 0) chk("spurious_done8", 64'd1, 64'd0);
            else begin
                e = sb8.pop_front();
                chk("q8", 64'(q8), e.q);
                chk("r8", 64'(r8), e.r);
                chk("dbz8", 64'(dbz8), 64'(e.z));
                chk("lat8", 64'(cyc - e.c0 + 1), 64'd10);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_flags", {61'd0, busy32, done32, dbz32}, 64'd0);
        chk("rst_q", 64'(q32), 64'd0);
        chk("rst_r", 64'(r32), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_flags", {61'd0, busy32, done32, dbz32}, 64'd0);

        go32(1'b0, 32'd100, 32'd7);
        chk("busy_after_start", 64'(busy32), 64'd1);
        drain();
        repeat (5) @(negedge clk);
        chk("hold_q", 64'(q32), 64'd14);
        chk("hold_r", 64'(r32), 64'd2);

        go32(1'b1, 32'hFFFF_FFF9, 32'd2);          drain();
        go32(1'b1, 32'd7, 32'hFFFF_FFFE);          drain();
        go32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);  drain();
        go32(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);  drain();
        go32(1'b1, 32'h0000_1234, 32'd0);          drain();
        chk("dbz_held", 64'(dbz32), 64'd1);
        go32(1'b0, 32'd10, 32'd3);                 drain();
        go32(1'b1, 32'hFFFF_FF00, 32'd0);          drain();

        // a start while busy must be ignored
        go32(1'b0, 32'd1000, 32'd9);
        repeat (4) @(negedge clk);
        start32 = 1'b1;
        dvd32   = 32'd55;
        dvs32   = 32'd5;
        @(negedge clk);
        start32 = 1'b0;
        drain();

        // back-to-back: the second start lands in the DONE cycle
        go32(1'b1, 32'hFFFF_FC18, 32'd33);
        for (int i = 0; i < 100 && !done32; i++) @(negedge clk);
        go32(1'b0, 32'hDEAD_BEEF, 32'h1234);
        drain();

        // asynchronous reset mid-division aborts without done
        go32(1'b0, 32'd999, 32'd10);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        sb32.delete();
        #1;
        chk("abort_flags", {61'd0, busy32, done32, dbz32}, 64'd0);
        chk("abort_q", 64'(q32), 64'd0);
        chk("abort_r", 64'(r32), 64'd0);
        @(negedge clk);
        reset  = 1'b0;
        n_done = 0;
        repeat (40) @(negedge clk);
        chk("no_done_after_abort", 64'(n_done), 64'd0);

        go8(1'b1, 8'h81, 8'h03);  drain();
        go8(1'b0, 8'h81, 8'h03);  drain();
        go8(1'b1, 8'h80, 8'hFF);  drain();
        go8(1'b1, 8'h45, 8'h00);  drain();

        for (int i = 0; i < 12; i++) begin
            go32(1'($urandom_range(0, 1)), $urandom, (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom);
            go8(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom_range(0, 255)));
            drain();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
